// File: rtl/hub75_pkg.sv
// Shared types and panel geometry for the HUB75 receive-side capture block.
package hub75_pkg;

  localparam int COLS = 32;
  localparam int ROWS = 16;
  localparam int SCAN = ROWS / 2;

  typedef logic [2:0]      rgb_t;
  typedef rgb_t [COLS-1:0] row_t;

  typedef enum logic {
    ALIGN,
    RUN
  } cap_state_t;

endpackage

// File: rtl/hub75_sync_edge.sv
// Multi-flop synchronizer with rising-edge detect. Every bit sees the same
// delay, so signals synchronized through separate instances stay aligned.
module hub75_sync_edge #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o,
  output logic [WIDTH-1:0] rise_o
);

  logic [WIDTH-1:0] sync_q [STAGES];
  logic [WIDTH-1:0] prev_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < STAGES; i++) sync_q[i] <= '0;
      prev_q <= '0;
    end else begin
      sync_q[0] <= d_i;
      for (int i = 1; i < STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign q_o    = sync_q[STAGES-1];
  assign rise_o = q_o & ~prev_q;

endmodule

// File: rtl/hub75_capture.sv
// Oversampling HUB75 receiver: rebuilds the panel's shift/latch behaviour and
// stores every latched row pair into a resettable frame buffer.
module hub75_capture #(
  parameter int COLS        = hub75_pkg::COLS,
  parameter int ROWS        = hub75_pkg::ROWS,
  parameter int SYNC_STAGES = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      hub_clk,
  input  logic [5:0]                hub_rgb,
  input  logic                      hub_lat,
  input  logic [$clog2(ROWS/2)-1:0] hub_abc,
  input  logic [$clog2(ROWS)-1:0]   rd_row,
  input  logic [$clog2(COLS)-1:0]   rd_col,
  output logic [2:0]                rd_pix,
  output logic                      row_commit,
  output logic                      frame_done,
  output logic                      short_row_err,
  input  logic                      clr_err
);

  localparam int         SCAN    = ROWS / 2;
  localparam int         ABC_W   = $clog2(SCAN);
  localparam int         ROW_W   = $clog2(ROWS);
  localparam int         COL_W   = $clog2(COLS);
  localparam int         DATA_W  = 6 + ABC_W;
  localparam logic [5:0] CNT_MAX = 6'd63;

  import hub75_pkg::*;

  typedef rgb_t [COLS-1:0] line_t;

  logic [1:0]        ctl_level, ctl_rise;
  logic [DATA_W-1:0] data_q, data_rise;
  logic              clk_rise, lat_rise;
  rgb_t              rgb_top, rgb_bot;
  logic [ABC_W-1:0]  abc;

  hub75_sync_edge #(.WIDTH(2), .STAGES(SYNC_STAGES)) u_sync_ctl (
    .clk    (clk),
    .reset  (reset),
    .d_i    ({hub_clk, hub_lat}),
    .q_o    (ctl_level),
    .rise_o (ctl_rise)
  );

  hub75_sync_edge #(.WIDTH(DATA_W), .STAGES(SYNC_STAGES)) u_sync_data (
    .clk    (clk),
    .reset  (reset),
    .d_i    ({hub_rgb, hub_abc}),
    .q_o    (data_q),
    .rise_o (data_rise)
  );

  // Control levels and data edges are not needed; only the aligned pairs are.
  logic unused_sync;
  assign unused_sync = ^{ctl_level, data_rise};

  assign clk_rise = ctl_rise[1];
  assign lat_rise = ctl_rise[0];
  assign rgb_top  = data_q[DATA_W-1 -: 3];
  assign rgb_bot  = data_q[DATA_W-4 -: 3];
  assign abc      = data_q[ABC_W-1:0];

  cap_state_t       state_q, state_d;
  line_t            top_q, top_d, bot_q, bot_d;
  logic [5:0]       cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             commit_q, commit_d;
  logic             done_q, done_d;
  logic [2:0]       pix_q, pix_d;
  logic [ROW_W-1:0] top_row, bot_row;
  logic             col_ok;
  line_t            fb_q [ROWS];

  assign top_row = ROW_W'(abc);
  assign bot_row = ROW_W'(abc) + ROW_W'(SCAN);

  // The shift is resolved before the latch so a coincident latch commits the
  // post-shift contents and the incremented count.
  always_comb begin
    // NOTE: every next-state signal gets a default first so no path can infer a latch.
    state_d  = state_q;
    top_d    = top_q;
    bot_d    = bot_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    commit_d = 1'b0;
    done_d   = 1'b0;

    if (clr_err) err_d = 1'b0;

    if (state_q == RUN && clk_rise) begin
      top_d = {top_q[COLS-2:0], rgb_top};
      bot_d = {bot_q[COLS-2:0], rgb_bot};
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + 6'd1;
    end

    if (lat_rise) begin
      if (state_q == ALIGN) begin
        state_d = RUN;
      end else if (int'(cnt_d) >= COLS) begin
        commit_d = 1'b1;
        done_d   = (abc == ABC_W'(SCAN - 1));
      end else begin
        err_d = 1'b1;
      end
      cnt_d = '0;
    end
  end

  if ((1 << COL_W) > COLS) begin : g_col_guard
    assign col_ok = (rd_col < COL_W'(COLS));
  end else begin : g_col_full
    assign col_ok = 1'b1;
  end

  always_comb begin
    pix_d = '0;
    if (col_ok) pix_d = fb_q[rd_row][rd_col];
  end

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state_q  <= ALIGN;
      top_q    <= '0;
      bot_q    <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      commit_q <= 1'b0;
      done_q   <= 1'b0;
      pix_q    <= '0;
    end else begin
      state_q  <= state_d;
      top_q    <= top_d;
      bot_q    <= bot_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      commit_q <= commit_d;
      done_q   <= done_d;
      pix_q    <= pix_d;
    end
  end

  // NOTE: the frame buffer must read all-zero after reset, so it is built from resettable flops, not a RAM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < ROWS; r++) fb_q[r] <= '0;
    end else if (commit_d) begin
      fb_q[top_row] <= top_d;
      fb_q[bot_row] <= bot_d;
    end
  end

  assign rd_pix        = pix_q;
  assign row_commit    = commit_q;
  assign frame_done    = done_q;
  assign short_row_err = err_q;

endmodule

// File: tb/tb_hub75_capture.sv
// Self-checking bench for hub75_capture: drives a HUB75 stream at 1/8 of clk,
// scoreboards commits and compares frame-buffer reads against bench tables.
module tb_hub75_capture;
  timeunit 1ns;
  timeprecision 1ps;

  import hub75_pkg::*;

  localparam int SYNC = 2;

  logic       clk = 1'b0;
  logic       reset, hub_clk, hub_lat, clr_err;
  logic [5:0] hub_rgb;
  logic [2:0] hub_abc;
  logic [3:0] rd_row;
  logic [4:0] rd_col;
  logic [2:0] rd_pix;
  logic       row_commit, frame_done, short_row_err;

  int vec_cnt = 0;
  int err_cnt = 0;
  int fd_cnt  = 0;

  // One entry per expected commit: the frame_done value that commit must carry.
  bit exp_q[$];

  typedef struct {
    int   row;
    int   col;
    rgb_t pix;
  } rd_vec_t;
  rd_vec_t vecs[$];

  always #5 clk = ~clk;

  hub75_capture #(.SYNC_STAGES(SYNC)) dut (
    .clk           (clk),
    .reset         (reset),
    .hub_clk       (hub_clk),
    .hub_rgb       (hub_rgb),
    .hub_lat       (hub_lat),
    .hub_abc       (hub_abc),
    .rd_row        (rd_row),
    .rd_col        (rd_col),
    .rd_pix        (rd_pix),
    .row_commit    (row_commit),
    .frame_done    (frame_done),
    .short_row_err (short_row_err),
    .clr_err       (clr_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (frame_done) fd_cnt++;
    if (row_commit) begin
      if (exp_q.size() == 0) check("unexpected_row_commit", row_commit, 0);
      else                   check("frame_done_on_commit", frame_done, exp_q.pop_front());
    end else if (frame_done) begin
      check("frame_done_without_commit", frame_done, 0);
    end
  end

  task automatic shift(input rgb_t top, input rgb_t bot);
    hub_clk = 1'b0;
    hub_rgb = {top, bot};
    repeat (4) @(negedge clk);
    hub_clk = 1'b1;
    repeat (4) @(negedge clk);
    hub_clk = 1'b0;
  endtask

  task automatic latch(input int abc, input bit want_commit, input bit want_done);
    hub_abc = abc[2:0];
    repeat (2) @(negedge clk);
    if (want_commit) exp_q.push_back(want_done);
    hub_lat = 1'b1;
    repeat (4) @(negedge clk);
    hub_lat = 1'b0;
    repeat (6) @(negedge clk);
    check($sformatf("commits_outstanding_abc%0d", abc), exp_q.size(), 0);
  endtask

  task automatic rd_check(input string name, input int row, input int col, input rgb_t exp);
    rd_row = row[3:0];
    rd_col = col[4:0];
    @(negedge clk);
    check($sformatf("%s_r%0d_c%0d", name, row, col), rd_pix, exp);
  endtask

  task automatic run_vecs(input string name);
    foreach (vecs[i]) rd_check(name, vecs[i].row, vecs[i].col, vecs[i].pix);
    vecs.delete();
  endtask

  task automatic add_vec(input int row, input int col, input rgb_t pix);
    rd_vec_t v;
    v.row = row;
    v.col = col;
    v.pix = pix;
    vecs.push_back(v);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   fd_start;
    rgb_t c;

    reset   = 1'b1;
    hub_clk = 1'b0;
    hub_lat = 1'b0;
    hub_rgb = '0;
    hub_abc = '0;
    rd_row  = '0;
    rd_col  = '0;
    clr_err = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_rd_pix", rd_pix, 0);
    check("reset_row_commit", row_commit, 0);
    check("reset_frame_done", frame_done, 0);
    check("reset_short_row_err", short_row_err, 0);
    reset = 1'b0;
    @(negedge clk);

    // Partial row after reset is discarded by the first latch.
    repeat (10) shift(3'b111, 3'b111);
    latch(3, 1'b0, 1'b0);
    add_vec(3, 0, 3'b000);
    add_vec(3, 31, 3'b000);
    add_vec(11, 0, 3'b000);
    run_vecs("align");
    check("align_short_row_err", short_row_err, 0);

    // 37 shifts: only the last 32 samples are kept.
    for (int k = 0; k < 37; k++) shift(k < 5 ? 3'b100 : 3'b010, k < 5 ? 3'b100 : 3'b010);
    latch(2, 1'b1, 1'b0);
    for (int col = 0; col < COLS; col++) begin
      add_vec(2, col, 3'b010);
      add_vec(10, col, 3'b010);
    end
    run_vecs("single_row");

    // First sample shifted ends up in the highest column.
    for (int k = 0; k < 32; k++) shift(k == 0 ? 3'b100 : 3'b000, 3'b000);
    latch(0, 1'b1, 1'b0);
    add_vec(0, 31, 3'b100);
    add_vec(0, 0, 3'b000);
    add_vec(0, 15, 3'b000);
    for (int col = 0; col < COLS; col += 4) add_vec(8, col, 3'b000);
    run_vecs("col_order");

    // Full frame of a red/blue bar split at column 10.
    fd_start = fd_cnt;
    for (int abc = 0; abc < SCAN; abc++) begin
      for (int k = 0; k < 32; k++) begin
        c = (31 - k < 10) ? 3'b100 : 3'b001;
        shift(c, c);
      end
      latch(abc, 1'b1, abc == SCAN - 1);
    end
    check("frame_done_count", fd_cnt - fd_start, 1);
    for (int row = 2; row <= 5; row++)
      for (int col = 0; col < COLS; col++) add_vec(row, col, col < 10 ? 3'b100 : 3'b001);
    run_vecs("bar_frame");

    // Short row sets the sticky flag without writing.
    repeat (20) shift(3'b111, 3'b111);
    latch(4, 1'b0, 1'b0);
    check("short_row_err_set", short_row_err, 1);
    rd_check("short_row_nowrite", 4, 5, 3'b100);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    @(negedge clk);
    check("short_row_err_cleared", short_row_err, 0);

    // clr_err held through the cycle the second short row is detected.
    repeat (20) shift(3'b111, 3'b111);
    hub_abc = 3'd4;
    repeat (2) @(negedge clk);
    hub_lat = 1'b1;
    clr_err = 1'b1;
    repeat (SYNC + 1) @(negedge clk);
    clr_err = 1'b0;
    repeat (3) @(negedge clk);
    hub_lat = 1'b0;
    repeat (6) @(negedge clk);
    check("short_row_err_beats_clr", short_row_err, 1);
    rd_check("short_row2_nowrite", 4, 20, 3'b001);

    // Reset in the middle of a row: everything clears and alignment restarts.
    repeat (15) shift(3'b010, 3'b010);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("midreset_short_row_err", short_row_err, 0);
    rd_check("midreset_fb_cleared", 2, 5, 3'b000);
    for (int pass = 0; pass < 2; pass++) begin
      for (int k = 0; k < 32; k++) begin
        c = rgb_t'(31 - k);
        shift(c, ~c);
      end
      latch(1, pass == 1, 1'b0);
    end
    for (int col = 0; col < COLS; col++) begin
      c = rgb_t'(col);
      add_vec(1, col, c);
      add_vec(9, col, ~c);
    end
    run_vecs("midreset_row");

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
